// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause field positions,
// exception codes and EPC-source encodings.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [4:0] EXC_TR  = 5'd13;

  typedef enum logic [1:0] {
    SEL_IF  = 2'b00,
    SEL_ID  = 2'b01,
    SEL_EXE = 2'b10,
    SEL_MEM = 2'b11
  } selepc_e;

  // Cause layout: BD[31], IP[15:8], ExcCode[6:2]; every other bit reads 0.
  function automatic logic [31:0] pack_cause(input logic bd, input logic [7:0] ip,
                                             input logic [4:0] exc);
    return {bd, 15'd0, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Control-unit <-> CP0 port bundle: exception strobes, mtc0/mfc0 access,
// stage PCs for EPC capture and the interrupt/eret results.
interface cp0_regfile_if #(parameter int PC_W = 32);

  logic [PC_W-1:0] pc_if, pc_id, pc_exe, pc_mem;
  logic            writestatus, writecause, writeepc;
  logic            exl, ie, db;
  logic [1:0]      selepc;
  logic [4:0]      exccode;
  logic            mtc0, mfc0;
  logic [4:0]      cp0_rd;
  logic [31:0]     cp0_wdata;
  logic [31:0]     cp0_rdata;
  logic            intr;
  logic [7:0]      imip;
  logic [PC_W-1:0] epc;

  modport master (
    output pc_if, pc_id, pc_exe, pc_mem,
    output writestatus, writecause, writeepc, exl, ie, db, selepc, exccode,
    output mtc0, mfc0, cp0_rd, cp0_wdata,
    input  cp0_rdata, intr, imip, epc
  );

  modport slave (
    input  pc_if, pc_id, pc_exe, pc_mem,
    input  writestatus, writecause, writeepc, exl, ie, db, selepc, exccode,
    input  mtc0, mfc0, cp0_rd, cp0_wdata,
    output cp0_rdata, intr, imip, epc
  );

endinterface

// File: rtl/cp0_timer.sv
// Free-running Count with Compare match; timer_pend is sticky until Compare
// is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  // NOTE: state updates use non-blocking assignments so the match below sees
  // the pre-increment Count of this cycle, not the value being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      compare    <= 32'hFFFF_FFFF;
      timer_pend <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare    <= wdata;
        timer_pend <= 1'b0;          // rewriting Compare acknowledges, even on a match
      end else if (count == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC with exception strobes,
// mtc0/mfc0 access, interrupt sampling and the Count/Compare timer.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          PC_W         = 32,
  parameter int          HW_INT_W     = 6,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HW_INT_W-1:0] hw_int,
  cp0_regfile_if.slave        bus
);

  logic [31:0]         status_q;
  logic                bd_q;
  logic [4:0]          exc_q;
  logic [1:0]          sw_ip_q;
  logic [HW_INT_W-1:0] hw_q;
  logic [PC_W-1:0]     epc_q;
  logic [PC_W-1:0]     epc_src;
  logic [31:0]         count, compare;
  logic                timer_pend;
  logic [5:0]          hw_ip;
  logic [7:0]          ip;
  logic [31:0]         rd_val;

  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  assign wr_status  = bus.mtc0 && (bus.cp0_rd == REG_STATUS);
  assign wr_cause   = bus.mtc0 && (bus.cp0_rd == REG_CAUSE);
  assign wr_epc     = bus.mtc0 && (bus.cp0_rd == REG_EPC);
  assign wr_count   = bus.mtc0 && (bus.cp0_rd == REG_COUNT);
  assign wr_compare = bus.mtc0 && (bus.cp0_rd == REG_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    epc_src = bus.pc_if;
    case (selepc_e'(bus.selepc))
      SEL_IF:  epc_src = bus.pc_if;
      SEL_ID:  epc_src = bus.pc_id;
      SEL_EXE: epc_src = bus.pc_exe;
      SEL_MEM: epc_src = bus.pc_mem;
      default: epc_src = bus.pc_if;
    endcase
  end

  // Exception strobes take priority over an mtc0 to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= RESET_STATUS & STATUS_WMASK;
      bd_q     <= 1'b0;
      exc_q    <= EXC_INT;
      sw_ip_q  <= '0;
      hw_q     <= '0;
      epc_q    <= '0;
    end else begin
      hw_q <= hw_int;

      if (bus.writestatus) begin
        status_q[ST_EXL] <= bus.exl;
        status_q[ST_IE]  <= bus.ie;
      end else if (wr_status) begin
        status_q <= bus.cp0_wdata & STATUS_WMASK;
      end

      if (bus.writecause) begin
        bd_q  <= bus.db;
        exc_q <= bus.exccode;
      end else if (wr_cause) begin
        sw_ip_q <= bus.cp0_wdata[9:8];
      end

      if (bus.writeepc) begin
        epc_q <= epc_src;
      end else if (wr_epc) begin
        epc_q <= bus.cp0_wdata[PC_W-1:0];
      end
    end
  end

  assign hw_ip = 6'(hw_q);
  assign ip    = {hw_ip[5] | timer_pend, hw_ip[4:0], sw_ip_q};

  always_comb begin
    rd_val = '0;
    case (bus.cp0_rd)
      REG_COUNT:   rd_val = count;
      REG_COMPARE: rd_val = compare;
      REG_STATUS:  rd_val = status_q;
      REG_CAUSE:   rd_val = pack_cause(bd_q, ip, exc_q);
      REG_EPC:     rd_val = 32'(epc_q);
      default:     rd_val = '0;
    endcase
  end

  assign bus.cp0_rdata = bus.mfc0 ? rd_val : 32'd0;
  assign bus.intr      = status_q[ST_IE] & ~status_q[ST_EXL];
  assign bus.imip      = status_q[15:8] & ip;
  assign bus.epc       = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed and randomized checks of cp0_regfile against a field-level model.
module tb_cp0_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hw_int;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  cp0_regfile_if #(.PC_W(32)) bus ();

  cp0_regfile #(.PC_W(32), .HW_INT_W(6), .RESET_STATUS(32'h0)) dut (
    .clk    (clk),
    .rst    (rst),
    .hw_int (hw_int),
    .bus    (bus)
  );

  // Reference model, kept as architectural fields.
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_pend;
  logic [4:0]  m_exc;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  logic [31:0] m_epc, m_count, m_compare;

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_pend, m_hw[4:0], m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'd0, m_ip(), 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] pcs [4];
    logic        hit;
    pcs[0] = bus.pc_if; pcs[1] = bus.pc_id; pcs[2] = bus.pc_exe; pcs[3] = bus.pc_mem;
    if (rst) begin
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = 0; m_sw = 0; m_hw = 0;
      m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_pend = 0;
    end else begin
      hit = (m_count == m_compare);
      if (bus.mtc0 && bus.cp0_rd == 5'd11) begin
        m_compare = bus.cp0_wdata; m_pend = 0;
      end else if (hit) m_pend = 1;
      if (bus.mtc0 && bus.cp0_rd == 5'd9) m_count = bus.cp0_wdata;
      else m_count = m_count + 1;
      if (bus.writestatus) begin
        m_exl = bus.exl; m_ie = bus.ie;
      end else if (bus.mtc0 && bus.cp0_rd == 5'd12) begin
        m_im = bus.cp0_wdata[15:8]; m_exl = bus.cp0_wdata[1]; m_ie = bus.cp0_wdata[0];
      end
      if (bus.writecause) begin
        m_bd = bus.db; m_exc = bus.exccode;
      end else if (bus.mtc0 && bus.cp0_rd == 5'd13) m_sw = bus.cp0_wdata[9:8];
      if (bus.writeepc) m_epc = pcs[bus.selepc];
      else if (bus.mtc0 && bus.cp0_rd == 5'd14) m_epc = bus.cp0_wdata;
      m_hw = hw_int;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.writestatus = 0; bus.writecause = 0; bus.writeepc = 0;
    bus.exl = 0; bus.ie = 0; bus.db = 0; bus.selepc = 0; bus.exccode = 0;
    bus.mtc0 = 0; bus.mfc0 = 0; bus.cp0_rd = 0; bus.cp0_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    bus.cp0_rd = idx; bus.mfc0 = 1; #1;
    check(tag, bus.cp0_rdata, exp);
    bus.mfc0 = 0;
  endtask

  task automatic mtc0(input logic [4:0] idx, input logic [31:0] wd);
    bus.mtc0 = 1; bus.cp0_rd = idx; bus.cp0_wdata = wd;
  endtask

  initial begin
    logic [31:0] cnt;
    logic [4:0]  ridx;
    bit          reached;
    rst = 1; hw_int = 0;
    bus.pc_if = 32'h100; bus.pc_id = 32'h80; bus.pc_exe = 32'h400; bus.pc_mem = 32'h500;
    clr();
    tick(); tick();
    rst = 0;

    // Reset state
    rd(5'd12, 32'h0, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd11, 32'hFFFF_FFFF, "rst_compare");
    check("rst_intr", 32'(bus.intr), 32'h0);
    check("rst_imip", 32'(bus.imip), 32'h0);
    check("rst_epc_out", bus.epc, 32'h0);

    // Status write plus hw interrupt; same-cycle mfc0 sees the old Status
    mtc0(5'd12, 32'h0000_FF01); hw_int = 6'h01;
    bus.mfc0 = 1; #1;
    check("mfc0_no_bypass", bus.cp0_rdata, 32'h0);
    check("imip_before_sample", 32'(bus.imip), 32'h0);
    tick(); clr();
    check("intr_enabled", 32'(bus.intr), 32'h1);
    check("imip_hw0", 32'(bus.imip), 32'h04);
    rd(5'd13, 32'h0000_0400, "cause_ip2");
    rd(5'd12, 32'h0000_FF01, "status_ff01");

    // Overflow exception with all three strobes
    bus.writestatus = 1; bus.writecause = 1; bus.writeepc = 1;
    bus.selepc = 2'b10; bus.exccode = 5'd12; bus.db = 1; bus.exl = 1; bus.ie = 1;
    tick(); clr();
    check("exc_epc", bus.epc, 32'h400);
    rd(5'd13, 32'h8000_0430, "exc_cause");
    check("exc_intr", 32'(bus.intr), 32'h0);
    bus.writestatus = 1; bus.exl = 0; bus.ie = 1;
    tick(); clr();
    check("eret_intr", 32'(bus.intr), 32'h1);
    rd(5'd12, 32'h0000_FF01, "eret_status");

    // Timer: Compare=5, Count=0, pending visible when Count reads 6
    hw_int = 0;
    mtc0(5'd11, 32'd5); tick(); clr();
    mtc0(5'd9, 32'd0);  tick(); clr();
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      bus.cp0_rd = 5'd9; bus.mfc0 = 1; #1;
      cnt = bus.cp0_rdata; bus.mfc0 = 0;
      check("timer_count", cnt, m_count);
      if (cnt == 32'd6) reached = 1;
      else begin
        check("timer_not_yet", 32'(bus.imip[7]), 32'h0);
        tick();
      end
    end
    check("timer_reached", 32'(reached), 32'h1);
    check("timer_imip", 32'(bus.imip), 32'h80);
    rd(5'd13, 32'h8000_8030, "timer_cause");
    tick(); tick();
    check("timer_sticky", 32'(bus.imip), 32'h80);
    mtc0(5'd11, 32'd1000); tick(); clr();
    check("timer_clear", 32'(bus.imip), 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF); tick(); clr();
    rd(5'd9, 32'hFFFF_FFFF, "count_max");
    tick();
    rd(5'd9, 32'h0, "count_wrap");

    // Collisions
    bus.writeepc = 1; bus.selepc = 2'b01; mtc0(5'd14, 32'h1234);
    tick(); clr();
    check("coll_epc", bus.epc, 32'h80);
    rd(5'd14, 32'h80, "coll_epc_rd");
    mtc0(5'd13, 32'h0000_0300); bus.writestatus = 1; bus.exl = 0; bus.ie = 1;
    tick(); clr();
    rd(5'd13, 32'h8000_0330, "coll_cause_sw");
    check("sw_imip", 32'(bus.imip), 32'h03);
    mtc0(5'd12, 32'h0000_0001); bus.writestatus = 1; bus.exl = 1; bus.ie = 0;
    tick(); clr();
    rd(5'd12, 32'h0000_FF02, "coll_status");

    // Reset overrides strobes; unimplemented index
    rst = 1; bus.writeepc = 1; bus.selepc = 2'b11; bus.pc_mem = 32'hABC;
    tick(); rst = 0; clr();
    check("rst_over_epc", bus.epc, 32'h0);
    rd(5'd12, 32'h0, "rst_over_status");
    mtc0(5'd7, 32'hDEAD_BEEF); tick(); clr();
    rd(5'd7, 32'h0, "unimpl_reg");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      clr();
      rst              = ($urandom_range(0, 39) == 0);
      hw_int           = 6'($urandom);
      bus.pc_if        = $urandom; bus.pc_id = $urandom;
      bus.pc_exe       = $urandom; bus.pc_mem = $urandom;
      bus.writestatus  = ($urandom_range(0, 3) == 0);
      bus.writecause   = ($urandom_range(0, 3) == 0);
      bus.writeepc     = ($urandom_range(0, 3) == 0);
      bus.exl          = 1'($urandom); bus.ie = 1'($urandom); bus.db = 1'($urandom);
      bus.selepc       = 2'($urandom);
      bus.exccode      = 5'($urandom);
      case ($urandom_range(0, 6))
        0: ridx = 5'd7;  1: ridx = 5'd9;  2: ridx = 5'd11; 3: ridx = 5'd12;
        4: ridx = 5'd13; 5: ridx = 5'd14; default: ridx = 5'($urandom);
      endcase
      bus.mtc0      = ($urandom_range(0, 2) == 0);
      bus.cp0_rd    = ridx;
      bus.cp0_wdata = (ridx == 5'd11 && $urandom_range(0, 1) == 1) ? m_count + 32'd2 : $urandom;
      bus.mfc0      = 1;
      #1;
      check("rnd_rdata", bus.cp0_rdata, m_read(ridx));
      check("rnd_intr", 32'(bus.intr), 32'(m_ie & ~m_exl));
      check("rnd_imip", 32'(bus.imip), 32'(m_im & m_ip()));
      check("rnd_epc", bus.epc, m_epc);
      tick();
    end
    rst = 0; clr();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
